// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the sram_ctrl initiator: FSM encoding, default
// timing parameters and the wait-counter width helper.
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_WSTROBE = 3'd2,
      ST_WHOLD   = 3'd3,
      ST_RDEN    = 3'd4
   } state_t;

   localparam int DEF_SETUP_CYC = 1;
   localparam int DEF_RD_WAIT   = 1;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold a wait count of maxv; never narrower than one bit.
   function automatic int cnt_width(input int maxv);
      return (maxv < 2) ? 1 : $clog2(maxv + 1);
   endfunction

endpackage

// File: rtl/sram_ctrl_wait_cnt.sv
// Loadable down-counter used to time the setup and read-enable phases.
// expired is high during the last cycle of a loaded interval.
module sram_ctrl_wait_cnt #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= value;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   // A count of N loaded at an edge covers exactly N following cycles.
   assign expired = (cnt_reg <= W'(1));

endmodule

// File: rtl/sram_ctrl.sv
// Single-beat host-to-sram initiator: sequences cs/wr/rd around each access,
// one access in flight, all outputs registered.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int RD_WAIT   = DEF_RD_WAIT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          resp_valid,
   output logic [DW-1:0] resp_rdata,
   output logic          sram_cs,
   output logic          sram_wr,
   output logic          sram_rd,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_din,
   input  logic [DW-1:0] sram_dout
);

   localparam int CW = cnt_width(max2(SETUP_CYC, RD_WAIT));
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC);
   localparam logic [CW-1:0] RD_LD    = CW'(RD_WAIT);

   state_t        state_reg, state_next;
   logic          ready_reg, ready_next;
   logic          resp_valid_reg, resp_valid_next;
   logic [DW-1:0] resp_rdata_reg, resp_rdata_next;
   logic          cs_reg, cs_next;
   logic          wr_reg, wr_next;
   logic          rd_reg, rd_next;
   logic          we_reg, we_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic [DW-1:0] din_reg, din_next;

   logic          cnt_load;
   logic [CW-1:0] cnt_value;
   logic          cnt_expired;

   sram_ctrl_wait_cnt #(
      .W (CW)
   ) u_wait_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (cnt_load),
      .value   (cnt_value),
      .expired (cnt_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         ready_reg      <= 1'b0;
         resp_valid_reg <= 1'b0;
         resp_rdata_reg <= '0;
         cs_reg         <= 1'b0;
         wr_reg         <= 1'b0;
         rd_reg         <= 1'b1;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         din_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         ready_reg      <= ready_next;
         resp_valid_reg <= resp_valid_next;
         resp_rdata_reg <= resp_rdata_next;
         cs_reg         <= cs_next;
         wr_reg         <= wr_next;
         rd_reg         <= rd_next;
         we_reg         <= we_next;
         addr_reg       <= addr_next;
         din_reg        <= din_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      ready_next      = ready_reg;
      resp_valid_next = 1'b0;
      resp_rdata_next = resp_rdata_reg;
      cs_next         = cs_reg;
      wr_next         = 1'b0;
      rd_next         = rd_reg;
      we_next         = we_reg;
      addr_next       = addr_reg;
      din_next        = din_reg;
      cnt_load        = 1'b0;
      cnt_value       = SETUP_LD;

      case (state_reg)
         ST_IDLE: begin
            ready_next = 1'b1;
            cs_next    = 1'b0;
            rd_next    = 1'b1;
            // Acceptance uses the registered ready, so nothing is taken on the
            // first edge after reset release.
            if (req_valid && ready_reg) begin
               addr_next  = req_addr;
               din_next   = req_wdata;
               we_next    = req_we;
               cs_next    = 1'b1;
               ready_next = 1'b0;
               cnt_load   = 1'b1;
               cnt_value  = SETUP_LD;
               state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_expired) begin
               if (we_reg) begin
                  wr_next    = 1'b1;
                  state_next = ST_WSTROBE;
               end else begin
                  rd_next    = 1'b0;
                  cnt_load   = 1'b1;
                  cnt_value  = RD_LD;
                  state_next = ST_RDEN;
               end
            end
         end
         ST_WSTROBE: begin
            state_next = ST_WHOLD;
         end
         ST_WHOLD: begin
            cs_next    = 1'b0;
            ready_next = 1'b1;
            state_next = ST_IDLE;
         end
         ST_RDEN: begin
            if (cnt_expired) begin
               resp_rdata_next = sram_dout;
               resp_valid_next = 1'b1;
               rd_next         = 1'b1;
               cs_next         = 1'b0;
               ready_next      = 1'b1;
               state_next      = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign req_ready  = ready_reg;
   assign resp_valid = resp_valid_reg;
   assign resp_rdata = resp_rdata_reg;
   assign sram_cs    = cs_reg;
   assign sram_wr    = wr_reg;
   assign sram_rd    = rd_reg;
   assign sram_addr  = addr_reg;
   assign sram_din   = din_reg;

endmodule
